// File: rtl/dram_port_arbiter.sv
// Purpose: shares one single-port image DRAM between UART rx (write), processor (r/w) and transmitter (read).
// Latency: grant is combinational; DRAM command one cycle after grant; read data/rvalid READ_LAT+1 cycles after grant.
// Backpressure: a requester holds req/addr/data until its gnt; one grant per cycle, round-robin among mode-enabled requesters.
module dram_port_arbiter #(
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 2     // legal range 1..4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [1:0]        mode,
    input  logic              rx_req,
    input  logic [ADDR_W-1:0] rx_addr,
    input  logic [DATA_W-1:0] rx_wdata,
    output logic              rx_gnt,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    input  logic              tx_req,
    input  logic [ADDR_W-1:0] tx_addr,
    output logic              tx_gnt,
    output logic              tx_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_data,
    output logic              dm_wren,
    output logic              dm_rden,
    input  logic [DATA_W-1:0] dm_q,
    output logic              illegal_req
);

    // Round-robin pointer names the requester the next search starts from.
    typedef enum logic [1:0] {
        SRC_RX  = 2'd0,
        SRC_CPU = 2'd1,
        SRC_TX  = 2'd2
    } src_t;

    // Owner of a read travelling through the DRAM latency.
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_CPU  = 2'd1,
        TAG_TX   = 2'd2
    } tag_t;

    src_t              rr_ptr;
    src_t              rr_ptr_nxt;
    logic              rx_en, cpu_en, tx_en;
    logic              rx_ok, cpu_ok, tx_ok;
    logic              accept;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic              win_wr;
    logic              win_rd;
    tag_t              win_tag;
    tag_t              tag_pipe [READ_LAT];
    tag_t              tag_out;

    // Mode gating: receive lets rx+cpu in, process cpu only, transmit tx+cpu, idle nobody.
    assign rx_en  = (mode == 2'b01);
    assign cpu_en = (mode != 2'b00);
    assign tx_en  = (mode == 2'b11);

    assign rx_ok  = rx_req  & rx_en;
    assign cpu_ok = cpu_req & cpu_en;
    assign tx_ok  = tx_req  & tx_en;

    // Rotating priority search; grants are forced low while reset is held.
    always_comb begin
        rx_gnt  = 1'b0;
        cpu_gnt = 1'b0;
        tx_gnt  = 1'b0;
        if (reset_n) begin
            case (rr_ptr)
                SRC_CPU: begin
                    if (cpu_ok)     cpu_gnt = 1'b1;
                    else if (tx_ok) tx_gnt  = 1'b1;
                    else if (rx_ok) rx_gnt  = 1'b1;
                end
                SRC_TX: begin
                    if (tx_ok)       tx_gnt  = 1'b1;
                    else if (rx_ok)  rx_gnt  = 1'b1;
                    else if (cpu_ok) cpu_gnt = 1'b1;
                end
                default: begin
                    if (rx_ok)       rx_gnt  = 1'b1;
                    else if (cpu_ok) cpu_gnt = 1'b1;
                    else if (tx_ok)  tx_gnt  = 1'b1;
                end
            endcase
        end
    end

    assign accept = rx_gnt | cpu_gnt | tx_gnt;

    // Winner's command; with no winner the DRAM address/data simply hold.
    always_comb begin
        win_addr   = dm_addr;
        win_data   = dm_data;
        win_wr     = 1'b0;
        win_rd     = 1'b0;
        win_tag    = TAG_NONE;
        rr_ptr_nxt = rr_ptr;
        if (rx_gnt) begin
            win_addr   = rx_addr;
            win_data   = rx_wdata;
            win_wr     = 1'b1;
            rr_ptr_nxt = SRC_CPU;
        end else if (cpu_gnt) begin
            win_addr   = cpu_addr;
            win_data   = cpu_wdata;
            rr_ptr_nxt = SRC_TX;
            if (cpu_we) begin
                win_wr  = 1'b1;
            end else begin
                win_rd  = 1'b1;
                win_tag = TAG_CPU;
            end
        end else if (tx_gnt) begin
            win_addr   = tx_addr;
            win_rd     = 1'b1;
            win_tag    = TAG_TX;
            rr_ptr_nxt = SRC_RX;
        end
    end

    // Pointer advances past the granted requester; holds when nothing is granted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rr_ptr <= SRC_RX;
        else          rr_ptr <= rr_ptr_nxt;
    end

    // Registered DRAM port drive.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dm_addr <= '0;
            dm_data <= '0;
            dm_wren <= 1'b0;
            dm_rden <= 1'b0;
        end else begin
            dm_wren <= win_wr;
            dm_rden <= win_rd;
            if (accept) begin
                dm_addr <= win_addr;
                dm_data <= win_data;
            end
        end
    end

    // Read tag shifts alongside the DRAM latency, loaded on the same edge as dm_rden.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < READ_LAT; i++) tag_pipe[i] <= TAG_NONE;
        end else begin
            tag_pipe[0] <= win_tag;
            for (int i = 1; i < READ_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    assign tag_out = tag_pipe[READ_LAT-1];

    // Return stage: capture dm_q and pulse the owner's rvalid for one cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata      <= '0;
            cpu_rvalid <= 1'b0;
            tx_rvalid  <= 1'b0;
        end else begin
            cpu_rvalid <= (tag_out == TAG_CPU);
            tx_rvalid  <= (tag_out == TAG_TX);
            if (tag_out != TAG_NONE) rdata <= dm_q;
        end
    end

    // Sticky flag for any request arriving from a requester the current mode disables.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            illegal_req <= 1'b0;
        else if ((rx_req & ~rx_en) | (cpu_req & ~cpu_en) | (tx_req & ~tx_en))
            illegal_req <= 1'b1;
    end

endmodule
